// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad peripheral: register map, bit
// positions, key FSM states and scanner frame results.
package keypad_pkg;

  localparam int unsigned ADDR_DATA   = 0;
  localparam int unsigned ADDR_STATUS = 1;
  localparam int unsigned ADDR_CTRL   = 2;
  localparam int unsigned ADDR_DEB    = 3;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_CLEAR  = 1;
  localparam int unsigned CTRL_IRQEN  = 2;

  localparam int unsigned STAT_EMPTY  = 0;
  localparam int unsigned STAT_FULL   = 1;
  localparam int unsigned STAT_OVF    = 2;
  localparam int unsigned STAT_COUNT  = 8;

  localparam int unsigned DATA_VALID  = 15;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_DEB,
    KEY_HELD,
    KEY_REL
  } key_state_t;

  typedef enum logic [1:0] {
    FRAME_NONE,
    FRAME_ONE,
    FRAME_MULTI
  } frame_t;

  // A debounce setting of zero behaves like one frame.
  function automatic logic [7:0] deb_frames(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Row sequencer for the keypad matrix: synchronises the column inputs, drives
// one row at a time and classifies each full frame as NONE, ONE(code) or MULTI.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned nRows   = 4,
  parameter int unsigned nCols   = 4,
  parameter int unsigned scanDiv = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [nCols-1:0] cols,
  output logic [nRows-1:0] rows,
  output logic             frame_done,
  output frame_t           result,
  output logic [7:0]       code
);

  localparam int unsigned DW = (scanDiv > 1) ? $clog2(scanDiv) : 1;
  localparam int unsigned RW = $clog2(nRows);
  localparam int unsigned CW = $clog2(nCols);

  logic [nCols-1:0] cols_m, cols_s;
  logic [DW-1:0]    div;
  logic [RW-1:0]    row;
  logic [1:0]       acc_hits, row_hits, tot_hits;
  logic [7:0]       acc_code, row_code, tot_code;
  logic [CW-1:0]    row_col;
  logic             last_cycle, last_row;

  assign last_cycle = (div == DW'(scanDiv - 1));
  assign last_row   = (row == RW'(nRows - 1));
  assign rows       = enable ? (nRows'(1) << row) : '0;

  // Hit count saturates at 2: only "none / one / several" matters.
  always_comb begin
    row_hits = 2'd0;
    row_col  = '0;
    for (int unsigned c = 0; c < nCols; c++) begin
      if (cols_s[c]) begin
        if (row_hits == 2'd0) begin
          row_hits = 2'd1;
          row_col  = CW'(c);
        end else begin
          row_hits = 2'd2;
        end
      end
    end
    row_code = 8'(row) * 8'(nCols) + 8'(row_col);
  end

  always_comb begin
    tot_hits = 2'd2;
    tot_code = acc_code;
    if (acc_hits == 2'd0) begin
      tot_hits = row_hits;
      tot_code = row_code;
    end else if (row_hits == 2'd0) begin
      tot_hits = acc_hits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_m <= '0;
      cols_s <= '0;
    end else begin
      cols_m <= cols;
      cols_s <= cols_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      row        <= '0;
      acc_hits   <= 2'd0;
      acc_code   <= '0;
      frame_done <= 1'b0;
      result     <= FRAME_NONE;
      code       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        div      <= '0;
        row      <= '0;
        acc_hits <= 2'd0;
        acc_code <= '0;
      end else if (last_cycle) begin
        div <= '0;
        if (last_row) begin
          row        <= '0;
          acc_hits   <= 2'd0;
          acc_code   <= '0;
          frame_done <= 1'b1;
          code       <= tot_code;
          result     <= (tot_hits == 2'd0) ? FRAME_NONE :
                        (tot_hits == 2'd1) ? FRAME_ONE  : FRAME_MULTI;
        end else begin
          row      <= row + 1'b1;
          acc_hits <= tot_hits;
          acc_code <= tot_code;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_keypad.sv
// Memory-mapped matrix keypad controller: key FSM, code FIFO and register file.
// Define KEYPAD_IRQ_EN to add the registered irq output and CTRL irq_en bit.
module peripheral_keypad
  import keypad_pkg::*;
#(
  parameter int unsigned tamPro  = 16,
  parameter int unsigned tamAddr = 4,
  parameter int unsigned nRows   = 4,
  parameter int unsigned nCols   = 4,
  parameter int unsigned depth   = 8,
  parameter int unsigned scanDiv = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cs,
  input  logic               rd,
  input  logic               wr,
  input  logic [tamAddr-1:0] addr,
  input  logic [tamPro-1:0]  din,
  output logic [tamPro-1:0]  dout,
  input  logic [nCols-1:0]   cols,
  output logic [nRows-1:0]   rows
`ifdef KEYPAD_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int unsigned AW = $clog2(depth);

  logic             enable;
  logic [7:0]       deb;
  logic             frame_done;
  frame_t           result;
  logic [7:0]       fcode;
  key_state_t       state;
  logic [7:0]       cand, cnt;
  logic [8:0]       cnt_next;
  logic             reach;
  logic             push;
  logic [7:0]       push_code;
  logic [7:0]       mem [depth];
  logic [AW:0]      wr_ptr, rd_ptr, count;
  logic             empty, full, ovf;
  logic             rd_cyc, wr_cyc, do_pop, clear, wr_en;
  logic [tamPro-1:0] rdata;
  logic             unused_din;

  keypad_scan #(
    .nRows  (nRows),
    .nCols  (nCols),
    .scanDiv(scanDiv)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cols      (cols),
    .rows      (rows),
    .frame_done(frame_done),
    .result    (result),
    .code      (fcode)
  );

  assign count  = wr_ptr - rd_ptr;
  assign empty  = (count == '0);
  assign full   = count[AW];
  assign rd_cyc = cs && rd;
  assign wr_cyc = cs && wr;
  assign do_pop = rd_cyc && (addr == tamAddr'(ADDR_DATA)) && !empty;
  assign clear  = wr_cyc && (addr == tamAddr'(ADDR_CTRL)) && din[CTRL_CLEAR];
  assign wr_en  = push && !clear && (!full || do_pop);

  assign cnt_next = {1'b0, cnt} + 9'd1;
  assign reach    = (cnt_next >= {1'b0, deb_frames(deb)});

`ifdef KEYPAD_IRQ_EN
  logic irq_en;
  assign unused_din = ^din[tamPro-1:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_cyc && addr == tamAddr'(ADDR_CTRL)) irq_en <= din[CTRL_IRQEN];
      irq <= irq_en && !empty;
    end
  end
`else
  assign unused_din = ^{din[tamPro-1:8], din[CTRL_IRQEN]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable <= 1'b0;
      deb    <= 8'd3;
    end else if (wr_cyc) begin
      if (addr == tamAddr'(ADDR_CTRL)) enable <= din[CTRL_ENABLE];
      if (addr == tamAddr'(ADDR_DEB))  deb    <= din[7:0];
    end
  end

  // Accepted codes leave the FSM as a registered one-cycle push pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= KEY_IDLE;
      cand      <= '0;
      cnt       <= '0;
      push      <= 1'b0;
      push_code <= '0;
    end else begin
      push <= 1'b0;
      if (!enable) begin
        state <= KEY_IDLE;
        cnt   <= '0;
      end else if (frame_done) begin
        case (state)
          KEY_IDLE: if (result == FRAME_ONE) begin
            state <= KEY_DEB;
            cand  <= fcode;
            cnt   <= 8'd1;
          end
          KEY_DEB: if (result == FRAME_ONE && fcode == cand) begin
            if (reach) begin
              push      <= 1'b1;
              push_code <= cand;
              state     <= KEY_HELD;
            end else begin
              cnt <= cnt_next[7:0];
            end
          end else begin
            state <= KEY_IDLE;
          end
          KEY_HELD: if (result == FRAME_NONE) begin
            state <= KEY_REL;
            cnt   <= 8'd1;
          end
          KEY_REL: if (result == FRAME_NONE) begin
            if (reach) state <= KEY_IDLE;
            else       cnt   <= cnt_next[7:0];
          end else begin
            state <= KEY_HELD;
            cnt   <= '0;
          end
          default: state <= KEY_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (push && full && !do_pop) ovf <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      tamAddr'(ADDR_DATA): if (!empty) begin
        rdata[DATA_VALID] = 1'b1;
        rdata[7:0]        = mem[rd_ptr[AW-1:0]];
      end
      tamAddr'(ADDR_STATUS): begin
        rdata[STAT_EMPTY]                 = empty;
        rdata[STAT_FULL]                  = full;
        rdata[STAT_OVF]                   = ovf;
        rdata[STAT_COUNT+4:STAT_COUNT]    = 5'(count);
      end
      tamAddr'(ADDR_CTRL): begin
        rdata[CTRL_ENABLE] = enable;
`ifdef KEYPAD_IRQ_EN
        rdata[CTRL_IRQEN]  = irq_en;
`endif
      end
      tamAddr'(ADDR_DEB): rdata[7:0] = deb;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= rd_cyc ? rdata : '0;
  end

endmodule

// File: tb/tb_peripheral_keypad.sv
// Directed bench for peripheral_keypad on a 4x4 matrix with a short scan period.
module tb_peripheral_keypad;

  localparam int unsigned FRAME = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [15:0] keys = '0;
  logic [15:0] rv;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
`ifdef KEYPAD_IRQ_EN
  logic        irq;
  logic        irq_seen;
`endif

  always #5 clk = ~clk;

  peripheral_keypad #(
    .tamPro (16),
    .tamAddr(4),
    .nRows  (4),
    .nCols  (4),
    .depth  (8),
    .scanDiv(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cs   (cs),
    .rd   (rd),
    .wr   (wr),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .cols (cols),
    .rows (rows)
`ifdef KEYPAD_IRQ_EN
    ,
    .irq  (irq)
`endif
  );

  // Key matrix: key r*4+c connects row r to column c while pressed.
  always_comb begin
    cols = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (rows[r] && keys[r*4+c]) cols[c] = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; din = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    d = dout;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(tag, {16'h0, d}, {16'h0, exp});
  endtask

  task automatic wait_frames(input int unsigned n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  // Press one key long enough to be accepted, then release long enough to rearm.
  task automatic tap_key(input int unsigned k);
    keys = '0;
    keys[k] = 1'b1;
    wait_frames(4);
    keys = '0;
    wait_frames(4);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rows_in_reset", {28'h0, rows}, 32'h0);
    rst_n = 1'b1;

    // Reset state
    read_check("status_reset", 4'h1, 16'h0001);
    read_check("data_empty", 4'h0, 16'h0000);
    read_check("deb_reset", 4'h3, 16'h0003);
    read_check("ctrl_reset", 4'h2, 16'h0000);
    read_check("unmapped", 4'h7, 16'h0000);
    check("rows_idle", {28'h0, rows}, 32'h0);

    // Single key, DEBOUNCE=2
    bus_write(4'h3, 16'h0002);
    bus_write(4'h2, 16'h0001);
    check("rows_start", {28'h0, rows}, 32'h1);
    read_check("ctrl_enabled", 4'h2, 16'h0001);
    keys[6] = 1'b1;
    wait_frames(5);
    keys = '0;
    wait_frames(4);
    read_check("status_one", 4'h1, 16'h0100);
    read_check("data_key6", 4'h0, 16'h8006);
    read_check("status_after_pop", 4'h1, 16'h0001);

    // Bouncing key with DEBOUNCE=3 never reaches the FIFO
    bus_write(4'h3, 16'h0003);
    for (int i = 0; i < 6; i++) begin
      keys[6] = 1'b1;
      wait_frames(1);
      keys[6] = 1'b0;
      wait_frames(1);
    end
    wait_frames(4);
    read_check("status_bounce", 4'h1, 16'h0001);

    // Nine keys into an eight-entry FIFO
    bus_write(4'h3, 16'h0002);
    for (int k = 0; k < 9; k++) tap_key(k);
    read_check("status_overflow", 4'h1, 16'h0806);
    for (int k = 0; k < 8; k++) read_check("data_order", 4'h0, 16'h8000 | 16'(k));
    read_check("status_drained", 4'h1, 16'h0005);
    bus_write(4'h2, 16'h0003);
    read_check("status_cleared", 4'h1, 16'h0001);
    read_check("ctrl_after_clear", 4'h2, 16'h0001);

    // Two keys at once are ignored; the survivor is accepted after release of the other
    keys = '0;
    keys[5] = 1'b1;
    keys[10] = 1'b1;
    wait_frames(4);
    read_check("status_multi", 4'h1, 16'h0001);
    keys[10] = 1'b0;
    wait_frames(4);
    keys = '0;
    wait_frames(4);
    read_check("status_survivor", 4'h1, 16'h0100);
    read_check("data_key5", 4'h0, 16'h8005);

    // Asynchronous reset mid-debounce with entries queued
    tap_key(1);
    tap_key(2);
    tap_key(3);
    read_check("status_three", 4'h1, 16'h0300);
    bus_write(4'h3, 16'h0005);
    keys[4] = 1'b1;
    wait_frames(1);
    @(negedge clk);
    check("rows_active", {31'h0, rows != 4'h0}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check("rows_async_reset", {28'h0, rows}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    keys = '0;
    read_check("status_post_reset", 4'h1, 16'h0001);
    read_check("ctrl_post_reset", 4'h2, 16'h0000);
    read_check("deb_post_reset", 4'h3, 16'h0003);

`ifdef KEYPAD_IRQ_EN
    bus_write(4'h3, 16'h0002);
    bus_write(4'h2, 16'h0005);
    read_check("ctrl_irq_en", 4'h2, 16'h0005);
    check("irq_idle", {31'h0, irq}, 32'h0);
    keys[9] = 1'b1;
    irq_seen = 1'b0;
    for (int i = 0; i < 8 * FRAME && !irq_seen; i++) begin
      @(negedge clk);
      irq_seen = irq;
    end
    check("irq_rise", {31'h0, irq_seen}, 32'h1);
    keys = '0;
    wait_frames(4);
    read_check("data_key9", 4'h0, 16'h8009);
    repeat (2) @(negedge clk);
    check("irq_fall", {31'h0, irq}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
